// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter
// Front end for the single read/write port (port 0) of the SRAM wrapper.
// Requester A issues single-word loads/stores; requester B issues aligned
// line-fill bursts of BURST_LEN read beats. SRAM port-0 controls are driven
// combinationally from the beat chosen this cycle (the wrapper samples them
// at the next posedge). Read data comes back through a two-stage tag pipeline
// that matches the wrapper's fixed two-cycle read latency, tagged with the
// requester id and a last-beat flag for bursts.
//
// Build option: define SRAM_ARB_RR_EN to replace the fixed A-over-B priority
// in IDLE with round-robin arbitration (a whole burst counts as one B grant).
// With the macro undefined, A always wins and B can starve.
module sram_port0_arbiter #(
    parameter int ADDR_LEN  = 10,
    parameter int WORD_SIZE = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   a_we,
    input  logic [ADDR_LEN-1:0]    a_addr,
    input  logic [WORD_SIZE-1:0]   a_wdata,
    input  logic [WORD_SIZE/8-1:0] a_wmask,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [ADDR_LEN-1:0]    b_addr,
    output logic                   nce0,
    output logic                   nwe0,
    output logic [ADDR_LEN-1:0]    addr0,
    output logic [WORD_SIZE-1:0]   wdata0,
    output logic [WORD_SIZE/8-1:0] wmask0,
    input  logic [WORD_SIZE-1:0]   rdata0,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic                   rsp_last,
    output logic [WORD_SIZE-1:0]   rsp_data
);

    localparam int OFF_W  = $clog2(BURST_LEN);
    localparam int MASK_W = WORD_SIZE / 8;

    localparam logic [OFF_W-1:0]     CNT_ZERO       = {OFF_W{1'b0}};
    localparam logic [OFF_W-1:0]     CNT_ONE        = OFF_W'(32'd1);
    localparam logic [OFF_W-1:0]     CNT_LAST       = OFF_W'(BURST_LEN - 1);
    localparam logic [ADDR_LEN-1:0]  ADDR_ZERO      = {ADDR_LEN{1'b0}};
    localparam logic [ADDR_LEN-1:0]  LINE_BASE_MASK = ~(ADDR_LEN'(BURST_LEN - 1));
    localparam logic [WORD_SIZE-1:0] DATA_ZERO      = {WORD_SIZE{1'b0}};
    localparam logic [MASK_W-1:0]    MASK_ZERO      = {MASK_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Line base of any address inside a BURST_LEN-aligned line.
    function automatic logic [ADDR_LEN-1:0] line_base(input logic [ADDR_LEN-1:0] addr);
        return addr & LINE_BASE_MASK;
    endfunction

    // Beat address inside a line: offset never carries into the line base.
    function automatic logic [ADDR_LEN-1:0] beat_addr(input logic [ADDR_LEN-1:0] base,
                                                      input logic [OFF_W-1:0]    off);
        return base | ADDR_LEN'(off);
    endfunction

    // FSM and burst bookkeeping
    state_t              state_r;
    state_t              state_nxt_s;
    logic [OFF_W-1:0]    cnt_r;
    logic [OFF_W-1:0]    cnt_nxt_s;
    logic [ADDR_LEN-1:0] base_r;
    logic [ADDR_LEN-1:0] base_nxt_s;

    // Arbitration
    logic                arb_open_s;
    logic                grant_a_s;
    logic                grant_b_s;

    // Port drive for the beat chosen this cycle
    logic                a_ready_s;
    logic                b_ready_s;
    logic                nce_s;
    logic                nwe_s;
    logic [ADDR_LEN-1:0] addr_s;
    logic [WORD_SIZE-1:0] wdata_s;
    logic [MASK_W-1:0]   wmask_s;

    // Tag of the beat issued this cycle (only reads carry a valid tag)
    logic                iss_rd_s;
    logic                iss_id_s;
    logic                iss_last_s;

    // Response tag pipeline and registered response outputs
    logic                s1_valid_r;
    logic                s1_id_r;
    logic                s1_last_r;
    logic                s2_valid_r;
    logic                s2_id_r;
    logic                s2_last_r;
    logic                rsp_valid_r;
    logic                rsp_id_r;
    logic                rsp_last_r;
    logic [WORD_SIZE-1:0] rsp_data_r;

    // New requests are only considered out of reset and between bursts.
    assign arb_open_s = rst && (state_r == ST_IDLE);

`ifdef SRAM_ARB_RR_EN
    // 1 when the most recent grant went to B (a full burst is one grant).
    logic last_grant_b_r;

    // Round-robin grant: on contention, favour whoever was not granted last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (arb_open_s) begin
            if (a_valid && b_valid) begin
                grant_a_s = last_grant_b_r;
                grant_b_s = !last_grant_b_r;
            end else begin
                grant_a_s = a_valid;
                grant_b_s = b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Remember which requester won the last arbitration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_b_r <= 1'b0;
        end else if (grant_a_s) begin
            last_grant_b_r <= 1'b0;
        end else if (grant_b_s) begin
            last_grant_b_r <= 1'b1;
        end else begin
            last_grant_b_r <= last_grant_b_r;
        end
    end
`else
    // Fixed priority grant: A always wins over B.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (arb_open_s) begin
            grant_a_s = a_valid;
            grant_b_s = !a_valid && b_valid;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end
`endif

    // Next-state logic and SRAM port drive for the beat issued this cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        base_nxt_s  = base_r;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        nce_s       = 1'b1;
        nwe_s       = 1'b1;
        addr_s      = ADDR_ZERO;
        wdata_s     = DATA_ZERO;
        wmask_s     = MASK_ZERO;
        iss_rd_s    = 1'b0;
        iss_id_s    = 1'b0;
        iss_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s) begin
                    a_ready_s = 1'b1;
                    nce_s     = 1'b0;
                    nwe_s     = !a_we;
                    addr_s    = a_addr;
                    wdata_s   = a_wdata;
                    wmask_s   = a_wmask;
                    iss_rd_s  = !a_we;
                    iss_id_s  = 1'b0;
                end else if (grant_b_s) begin
                    // Beat 0 goes out in the accept cycle; the rest follow back to back.
                    b_ready_s   = 1'b1;
                    nce_s       = 1'b0;
                    addr_s      = line_base(b_addr);
                    base_nxt_s  = line_base(b_addr);
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = ST_BURST;
                    iss_rd_s    = 1'b1;
                    iss_id_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (rst) begin
                    nce_s      = 1'b0;
                    addr_s     = beat_addr(base_r, cnt_r);
                    iss_rd_s   = 1'b1;
                    iss_id_s   = 1'b1;
                    iss_last_s = (cnt_r == CNT_LAST);
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                        state_nxt_s = ST_BURST;
                    end
                end else begin
                    // Reset abandons the burst: no further beats leave.
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, burst counter and latched line base.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            base_r  <= ADDR_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            base_r  <= base_nxt_s;
        end
    end

    // Two-stage tag shift aligned with the wrapper's read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 1'b0;
            s1_last_r  <= 1'b0;
            s2_valid_r <= 1'b0;
            s2_id_r    <= 1'b0;
            s2_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= iss_rd_s;
            s1_id_r    <= iss_id_s;
            s1_last_r  <= iss_last_s;
            s2_valid_r <= s1_valid_r;
            s2_id_r    <= s1_id_r;
            s2_last_r  <= s1_last_r;
        end
    end

    // Registered response: capture rdata0 when a tagged read matures, else hold data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_data_r  <= DATA_ZERO;
        end else if (s2_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= s2_id_r;
            rsp_last_r  <= s2_last_r;
            rsp_data_r  <= rdata0;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_data_r  <= rsp_data_r;
        end
    end

    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign nce0      = nce_s;
    assign nwe0      = nwe_s;
    assign addr0     = addr_s;
    assign wdata0    = wdata_s;
    assign wmask0    = wmask_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_last  = rsp_last_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Testbench for sram_port0_arbiter: a small SRAM model with a two-cycle read
// latency, a transaction-level reference model checked every cycle, and
// directed stimulus with hand-computed literal expectations.
module tb_sram_port0_arbiter;

    localparam int BL = 4;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic        a_we;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wmask;
    logic        b_valid;
    logic        b_ready;
    logic [9:0]  b_addr;
    logic        nce0;
    logic        nwe0;
    logic [9:0]  addr0;
    logic [31:0] wdata0;
    logic [3:0]  wmask0;
    logic [31:0] rdata0;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_last;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    sram_port0_arbiter #(.ADDR_LEN(10), .WORD_SIZE(32), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_wmask(a_wmask),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
        .nce0(nce0), .nwe0(nwe0), .addr0(addr0), .wdata0(wdata0), .wmask0(wmask0),
        .rdata0(rdata0),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_data(rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // SRAM model: address sampled at edge T, data on rdata0 after edge T+1.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_d1;
    always @(posedge clk) begin
        if (!nce0 && !nwe0) mem[addr0] <= merge(mem[addr0], wdata0, wmask0);
        if (!nce0 && nwe0) rd_d1 <= mem[addr0];
        rdata0 <= rd_d1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Reference model: transaction level, checked at every negedge.
    typedef struct {
        int          due;
        logic        id;
        logic        last;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [9:0]  beat_q[$];
    logic [31:0] shadow [0:1023];
    logic [31:0] hold_data = 32'h0;
`ifdef SRAM_ARB_RR_EN
    bit          m_last_b = 1'b0;
`endif

    initial begin : model
        logic ga, gb, ev;
        logic [3:0] e_ctrl;
        logic [9:0] e_addr, base;
        logic [31:0] e_wd;
        logic [3:0] e_wm;
        rsp_t r;
        forever begin
            @(negedge clk);
            // registered response outputs
            ev = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
            chk("m_rsp_valid", rsp_valid, ev);
            if (ev) begin
                r = rsp_q.pop_front();
                chk("m_rsp_id", rsp_id, r.id);
                chk("m_rsp_last", rsp_last, r.last);
                chk("m_rsp_data", rsp_data, r.data);
                hold_data = r.data;
            end else begin
                chk("m_rsp_hold", rsp_data, hold_data);
            end
            // combinational port drive for this cycle: {a_ready,b_ready,nce0,nwe0}
            e_ctrl = 4'b0011; e_addr = 10'h0; e_wd = 32'h0; e_wm = 4'h0;
            if (rst) begin
                if (beat_q.size() == 0) begin
`ifdef SRAM_ARB_RR_EN
                    if (a_valid && b_valid) begin ga = m_last_b; gb = !m_last_b; end
                    else begin ga = a_valid; gb = b_valid; end
                    if (ga) m_last_b = 1'b0;
                    if (gb) m_last_b = 1'b1;
`else
                    ga = a_valid;
                    gb = !a_valid && b_valid;
`endif
                    if (ga) begin
                        e_ctrl = {1'b1, 1'b0, 1'b0, !a_we};
                        e_addr = a_addr; e_wd = a_wdata; e_wm = a_wmask;
                        if (a_we) shadow[a_addr] = merge(shadow[a_addr], a_wdata, a_wmask);
                        else rsp_q.push_back('{cyc + 3, 1'b0, 1'b0, shadow[a_addr]});
                    end
                    if (gb) begin
                        base = b_addr & 10'h3FC;
                        for (int i = 0; i < BL; i++) beat_q.push_back(base + 10'(i));
                    end
                end
                if (beat_q.size() > 0) begin
                    e_ctrl = {1'b0, gb, 1'b0, 1'b1};
                    e_addr = beat_q[0];
                    rsp_q.push_back('{cyc + 3, 1'b1, beat_q.size() == 1, shadow[beat_q[0]]});
                    void'(beat_q.pop_front());
                end
                gb = 1'b0;
            end
            chk("m_ctrl", {a_ready, b_ready, nce0, nwe0}, e_ctrl);
            chk("m_addr0", addr0, e_addr);
            chk("m_wdata0", wdata0, e_wd);
            chk("m_wmask0", wmask0, e_wm);
            if (!rst) begin
                beat_q.delete();
                rsp_q.delete();
                hold_data = 32'h0;
`ifdef SRAM_ARB_RR_EN
                m_last_b = 1'b0;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic v, input logic we, input logic [9:0] ad,
                         input logic [31:0] d, input logic [3:0] m);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = d; a_wmask = m;
    endtask

    initial begin : stim
        int na, nb;
        rst = 1'b0; b_valid = 1'b0; b_addr = 10'h0;
        a_set(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);

        // reset with both requests pending: nothing accepted, port idle
        step(); a_set(1'b1, 1'b0, 10'h005, 32'h0, 4'h0); b_valid = 1'b1; b_addr = 10'h108; #1;
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_nce0", nce0, 1'b1);
        chk("rst_nwe0", nwe0, 1'b1);
        step(); rst = 1'b1; b_valid = 1'b0; a_set(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            chk("idle_nce0", nce0, 1'b1);
            chk("idle_rsp_valid", rsp_valid, 1'b0);
        end

        // preload line 0x100..0x10B through A writes
        for (int i = 0; i < 12; i++) begin
            step(); a_set(1'b1, 1'b1, 10'h100 + 10'(i), 32'hB000_0100 + 32'(i), 4'hF);
        end

        // A write then A read of 0x005
        step(); a_set(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        step(); a_set(1'b1, 1'b0, 10'h005, 32'h0, 4'h0); #1;
        chk("rd_nce0", nce0, 1'b0);
        chk("rd_nwe0", nwe0, 1'b1);
        chk("rd_addr0", addr0, 10'h005);
        step(); a_set(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        step(); #1;
        chk("rd_early", rsp_valid, 1'b0);
        step(); #1;
        chk("rd_valid", rsp_valid, 1'b1);
        chk("rd_id", rsp_id, 1'b0);
        chk("rd_data", rsp_data, 32'hDEADBEEF);

        // partial byte mask
        step(); a_set(1'b1, 1'b1, 10'h006, 32'hFFFFFFFF, 4'hF);
        step(); a_set(1'b1, 1'b1, 10'h006, 32'h12345678, 4'h5);
        step(); a_set(1'b1, 1'b0, 10'h006, 32'h0, 4'h0);
        step(); a_set(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        step();
        step(); #1;
        chk("mask_valid", rsp_valid, 1'b1);
        chk("mask_data", rsp_data, 32'hFF34FF78);
        for (int k = 0; k < 3; k++) step();

        // B burst at 0x10B: beats 0x108..0x10B, A held off, then A read
        for (int k = 0; k < 9; k++) begin
            step();
            b_valid = (k == 0); b_addr = 10'h10B;
            a_set((k >= 1) && (k <= 4), 1'b0, 10'h005, 32'h0, 4'h0);
            #1;
            if (k == 0) chk("bu_b_ready", b_ready, 1'b1);
            if (k < 4) chk("bu_addr0", addr0, 10'h108 + 10'(k));
            if (k < 4) chk("bu_nce0", nce0, 1'b0);
            if ((k >= 1) && (k <= 3)) chk("bu_a_held", a_ready, 1'b0);
            if (k == 4) chk("bu_a_after", a_ready, 1'b1);
            if ((k >= 3) && (k <= 6)) begin
                chk("bu_rsp_valid", rsp_valid, 1'b1);
                chk("bu_rsp_id", rsp_id, 1'b1);
                chk("bu_rsp_data", rsp_data, 32'hB000_0108 + 32'(k - 3));
                chk("bu_rsp_last", rsp_last, k == 6);
            end
            if (k == 7) begin
                chk("bu_a_rsp_id", rsp_id, 1'b0);
                chk("bu_a_rsp_data", rsp_data, 32'hDEADBEEF);
            end
        end
        for (int k = 0; k < 4; k++) step();

        // A and B both valid continuously
        na = 0; nb = 0;
        for (int k = 0; k < 20; k++) begin
            step(); a_set(1'b1, 1'b0, 10'h005, 32'h0, 4'h0); b_valid = 1'b1; b_addr = 10'h108; #1;
            na += int'(a_ready);
            nb += int'(b_ready);
        end
        step(); a_set(1'b0, 1'b0, 10'h0, 32'h0, 4'h0); b_valid = 1'b0;
`ifdef SRAM_ARB_RR_EN
        chk("rr_a_grants", na, 4);
        chk("rr_b_grants", nb, 4);
`else
        chk("prio_a_grants", na, 20);
        chk("prio_b_starved", nb, 0);
`endif
        for (int k = 0; k < 8; k++) step();

        // reset on burst beat 2
        step(); b_valid = 1'b1; b_addr = 10'h10A; #1;
        chk("rb_b_ready", b_ready, 1'b1);
        chk("rb_addr0_0", addr0, 10'h108);
        step(); b_valid = 1'b0; #1;
        chk("rb_addr0_1", addr0, 10'h109);
        step(); rst = 1'b0; #1;
        chk("rb_nce0", nce0, 1'b1);
        chk("rb_addr0_idle", addr0, 10'h0);
        step(); rst = 1'b1; b_valid = 1'b1; b_addr = 10'h105; #1;
        chk("rb_new_addr0", addr0, 10'h104);
        chk("rb_new_b_ready", b_ready, 1'b1);
        chk("rb_no_rsp_3", rsp_valid, 1'b0);
        step(); b_valid = 1'b0; #1;
        chk("rb_no_rsp_4", rsp_valid, 1'b0);
        step(); #1;
        chk("rb_no_rsp_5", rsp_valid, 1'b0);
        for (int k = 6; k < 10; k++) begin
            if (k > 6) step();
            else begin step(); end
            #1;
            chk("rb_rsp_valid", rsp_valid, 1'b1);
            chk("rb_rsp_data", rsp_data, 32'hB000_0104 + 32'(k - 6));
            chk("rb_rsp_last", rsp_last, k == 9);
        end
        for (int k = 0; k < 3; k++) step();

        // 8 back-to-back A reads of i*3
        for (int i = 0; i < 8; i++) begin
            step(); a_set(1'b1, 1'b1, 10'(i), 32'(i * 3), 4'hF);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (k < 8) a_set(1'b1, 1'b0, 10'(k), 32'h0, 4'h0);
            else a_set(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
            #1;
            if ((k >= 3) && (k <= 10)) begin
                chk("b2b_valid", rsp_valid, 1'b1);
                chk("b2b_id", rsp_id, 1'b0);
                chk("b2b_data", rsp_data, 32'((k - 3) * 3));
            end
            if (k == 11) chk("b2b_end", rsp_valid, 1'b0);
        end

        for (int k = 0; k < 5; k++) step();
        chk("drain", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_port0_arbiter.md
Name: sram_port0_arbiter

Overview:
- Front end for the 1rw port (port 0) of the SRAM wrapper.
- Arbitrates between two requesters:
  - requester A: single-word load/store.
  - requester B: line-fill engine issuing aligned burst reads of BURST_LEN words.
- Drives nce0/nwe0/addr0/wdata0/wmask0 and consumes rdata0.
- Returns read data tagged with requester id, using the wrapper's fixed 2-cycle read latency.

Parameters:
- ADDR_LEN, 10, word address width; matches the wrapper's addr0.
- WORD_SIZE, 32, data width; multiple of 32.
- BURST_LEN, 4, words per B burst; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted this cycle
- a_we  in  1  1=write, 0=read
- a_addr  in  ADDR_LEN  A word address
- a_wdata  in  WORD_SIZE  A write data
- a_wmask  in  WORD_SIZE/8  A byte write mask
- b_valid  in  1  B burst request valid
- b_ready  out  1  B burst accepted (base beat issued)
- b_addr  in  ADDR_LEN  B burst base; low log2(BURST_LEN) bits ignored
- nce0  out  1  SRAM port-0 chip enable, active low
- nwe0  out  1  SRAM port-0 write enable, active low
- addr0  out  ADDR_LEN  SRAM port-0 address
- wdata0  out  WORD_SIZE  SRAM port-0 write data
- wmask0  out  WORD_SIZE/8  SRAM port-0 byte mask
- rdata0  in  WORD_SIZE  SRAM port-0 read data
- rsp_valid  out  1  read response valid; no backpressure
- rsp_id  out  1  0=A, 1=B
- rsp_last  out  1  final beat of a B burst
- rsp_data  out  WORD_SIZE  read data

Behaviour:
- Reset (rst=0 at a posedge):
  - FSM goes to IDLE; burst counter = 0; response pipeline valids cleared.
  - rsp_valid/rsp_id/rsp_last/rsp_data = 0.
  - While rst is low: a_ready=b_ready=0, nce0=1, nwe0=1.
  - Reset mid-burst abandons the burst: remaining beats are not issued, and in-flight responses are dropped.
- Port drive:
  - SRAM controls are combinational from the beat issued this cycle; the wrapper samples them at the next posedge.
  - When no beat is issued: nce0=1, nwe0=1, addr0/wdata0/wmask0 = 0.
- FSM IDLE:
  - Fixed priority: if a_valid, a_ready=1 and A is issued (addr0=a_addr, nwe0=!a_we, wdata0/wmask0 from A).
  - Else if b_valid: b_ready=1, beat 0 issued (read, addr0={b_addr[hi], 0}), base latched, cnt<=1, go to BURST.
- FSM BURST:
  - a_ready=b_ready=0.
  - One read beat per cycle, no bubbles: addr0={base_hi, cnt}. Addresses stay inside the aligned line; there is no carry into base_hi.
  - When cnt==BURST_LEN-1: issue that beat, cnt<=0, return to IDLE.
  - The next IDLE cycle may accept A or a new B burst immediately.
- Response pipeline:
  - 2-stage shift of {valid, id, last}. Stage-1 valid is set only for issued reads (A with a_we=0, or any B beat).
  - Read accepted at edge T → rsp_valid high for exactly the cycle following edge T+2, with rsp_data=rdata0 registered at that edge.
  - Responses are strictly in issue order. A reads and B beats may be interleaved only across burst boundaries.
- Writes produce no response.
- rsp_last=1 only on the B beat with cnt==BURST_LEN-1.
- rsp_data holds its last value when rsp_valid=0.
- Back-to-back A reads: one response per cycle, 100% throughput.

Optional Feature:
- SRAM_ARB_RR_EN defined:
  - IDLE arbitration is round-robin via a last_grant flop (reset 0=A).
  - When both A and B are valid, the grant goes to the requester not granted last.
  - A whole burst counts as one B grant.
- Not defined: fixed A-over-B priority as above; B can starve under continuous A traffic.

Test Plan:
- Reset then idle → nce0=1, nwe0=1, rsp_valid=0 for 10 cycles; a_ready=0 while rst=0.
- A write addr 0x005, data 0xDEADBEEF, mask 0xF; then A read 0x005 → nce0=0/nwe0=1 on the read cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_data=0xDEADBEEF.
- B burst at b_addr 0x10B (BURST_LEN=4) → addr0 sequence 0x108, 0x109, 0x10A, 0x10B on consecutive cycles; 4 responses with rsp_id=1; rsp_last only on the 4th; a_ready=0 throughout the burst.
- A and B both valid continuously, macro undefined → only A granted, b_ready never 1. With SRAM_ARB_RR_EN → grants alternate A, B-burst (4 beats), A, B-burst…
- Assert rst=0 on burst beat 2 → next cycle nce0=1; no further rsp_valid; after release, a new burst starts at beat 0.
- 8 back-to-back A reads at addresses 0..7 preloaded with i*3 → 8 consecutive rsp_valid cycles, data 0, 3, …, 21, in order.
